// File: rtl/accum_frame_sched.sv
// accum_frame_sched: round-robin frame scheduler for a shared acc += x^4 datapath.
// Two channels request frames of lenN samples. The granted channel's samples go
// through a two-stage square/square pipeline into an accumulator. The frame sum
// is returned with a one-cycle result_valid pulse.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req[1:0]          level request per channel
//   len0, len1        frame lengths, sampled at grant
//   s_data/s_valid    sample stream from the granted channel
//   s_ready           sample accepted when s_valid && s_ready
//   grant[1:0]        one-hot datapath owner, 0 when idle
//   busy              high whenever not idle
//   result            frame sum, held until the next frame completes
//   result_valid      one-cycle completion pulse
//   result_chan       channel that owns result
module accum_frame_sched #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              result_chan
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  count;
    logic              drain_cnt;
    logic              last_served;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] sq;
    logic [DATA_W-1:0] q;
    logic              v1;
    logic              v2;

    logic              pick_c;
    logic [LEN_W-1:0]  pick_len_c;
    logic              start_c;
    logic              accept_c;
    logic [DATA_W-1:0] acc_nxt_c;

    // Arbitration: lone requester wins; on contention the channel not served last wins.
    always_comb begin
        pick_c = req[1];
        if (req == 2'b11) begin
            pick_c = ~last_served;
        end
        pick_len_c = pick_c ? len1 : len0;
    end

    assign start_c   = (state == IDLE) && (req != 2'b00);
    assign accept_c  = s_ready && s_valid;
    // Accumulator value after this edge; DONE captures it so the last term is included.
    assign acc_nxt_c = v2 ? (acc + q) : acc;

    // Datapath: stage 1 squares, stage 2 squares again, accumulator adds one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            sq  <= '0;
            q   <= '0;
            acc <= '0;
        end else begin
            v1 <= accept_c;
            v2 <= v1;
            if (accept_c) begin
                sq <= DATA_W'(s_data * s_data);
            end
            if (v1) begin
                q <= DATA_W'(sq * sq);
            end
            if (start_c) begin
                acc <= '0;
            end else begin
                acc <= acc_nxt_c;
            end
        end
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            drain_cnt    <= 1'b0;
            last_served  <= 1'b1;
            grant        <= 2'b00;
            busy         <= 1'b0;
            s_ready      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            result_chan  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_c) begin
                        grant       <= pick_c ? 2'b10 : 2'b01;
                        last_served <= pick_c;
                        count       <= pick_len_c;
                        busy        <= 1'b1;
                        if (pick_len_c != '0) begin
                            state   <= RUN;
                            s_ready <= 1'b1;
                        end else begin
                            // Empty frame: report a zero sum straight away.
                            state        <= DONE;
                            result       <= '0;
                            result_valid <= 1'b1;
                            result_chan  <= pick_c;
                        end
                    end
                end
                RUN: begin
                    if (s_valid) begin
                        count <= count - LEN_W'(1);
                        if (count == LEN_W'(1)) begin
                            state     <= DRAIN;
                            s_ready   <= 1'b0;
                            drain_cnt <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Second drain edge is the one that accumulates the last sample.
                    if (drain_cnt) begin
                        state        <= DONE;
                        result       <= acc_nxt_c;
                        result_valid <= 1'b1;
                        result_chan  <= last_served;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= 2'b00;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_frame_sched.sv
// Testbench for accum_frame_sched: directed frames plus randomized frames,
// checked against a frame-level model (round-robin pick, sum of x^4 mod 2^32).
module tb_accum_frame_sched;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [LW-1:0] len0;
    logic [LW-1:0] len1;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [1:0]    grant;
    logic          busy;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          result_chan;

    accum_frame_sched #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .len0         (len0),
        .len1         (len1),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .grant        (grant),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_chan  (result_chan)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic          model_last;
    logic [DW-1:0] smp [0:15];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference frame sum: x^4 for each sample, all arithmetic modulo 2^32.
    function automatic logic [DW-1:0] frame_sum(input int n);
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < n; i++) begin
            s = s + smp[i] * smp[i] * smp[i] * smp[i];
        end
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        req     = 2'b00;
        s_valid = 1'b0;
        @(negedge clk);
        rst        = 1'b0;
        model_last = 1'b1;
    endtask

    // One frame from the current IDLE negedge through the idle cycle after DONE.
    task automatic run_frame(input logic [1:0] rq, input int n, input int gap_lo,
                             input int gap_hi, input bit drop);
        logic          w;
        int            gcyc;
        int            rcyc;
        int            gap;
        bit            got;
        logic [DW-1:0] exp_sum;

        w          = (rq == 2'b11) ? ~model_last : rq[1];
        model_last = w;
        if (w) begin
            len1 = LW'(n);
            len0 = LW'($urandom_range(7, 0));
        end else begin
            len0 = LW'(n);
            len1 = LW'($urandom_range(7, 0));
        end
        req     = rq;
        exp_sum = frame_sum(n);

        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if (grant != 2'b00) got = 1'b1;
        end
        if (!got) begin
            check("grant_timeout", 64'd0, 64'd1);
            return;
        end
        gcyc = cyc;
        check("grant", 64'(grant), w ? 64'd2 : 64'd1);
        check("busy_on", 64'(busy), 64'd1);

        // Length changes and request drops after grant must not matter.
        len0 = LW'($urandom_range(9, 0));
        len1 = LW'($urandom_range(9, 0));
        if (drop) req[w] = 1'b0;

        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(gap_hi, gap_lo);
            for (int g = 0; g < gap; g++) begin
                s_valid = 1'b0;
                s_data  = $urandom;
                @(negedge clk);
            end
            check("s_ready_run", 64'(s_ready), 64'd1);
            s_valid = 1'b1;
            s_data  = smp[i];
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_data  = $urandom;

        got  = 1'b0;
        rcyc = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            if (result_valid) begin
                got  = 1'b1;
                rcyc = cyc;
            end else begin
                check("s_ready_drain", 64'(s_ready), 64'd0);
                @(negedge clk);
            end
        end
        if (!got) begin
            check("result_timeout", 64'd0, 64'd1);
            return;
        end
        check("result", 64'(result), 64'(exp_sum));
        check("result_chan", 64'(result_chan), 64'(w));
        // Counting the first granted cycle as 1, the pulse lands in cycle n+3.
        if (gap_hi == 0 && n > 0) begin
            check("latency", 64'(rcyc - gcyc + 1), 64'(n + 3));
        end

        @(negedge clk);
        check("rv_pulse", 64'(result_valid), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("grant_idle", 64'(grant), 64'd0);
        check("result_hold", 64'(result), 64'(exp_sum));
    endtask

    initial begin
        bit saw_rv;

        rst        = 1'b1;
        req        = 2'b00;
        len0       = '0;
        len1       = '0;
        s_data     = '0;
        s_valid    = 1'b0;
        model_last = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_rv", 64'(result_valid), 64'd0);
        check("rst_chan", 64'(result_chan), 64'd0);
        rst = 1'b0;

        // Basic frame: 1,2,3 on channel 0.
        smp[0] = 32'd1; smp[1] = 32'd2; smp[2] = 32'd3;
        run_frame(2'b01, 3, 0, 0, 1'b0);

        // Both requesting: alternation 0,1,0 with one idle cycle between frames.
        do_reset();
        smp[0] = 32'd2;
        run_frame(2'b11, 1, 0, 0, 1'b0);
        smp[0] = -32'sd3;
        run_frame(2'b11, 1, 0, 0, 1'b0);
        smp[0] = 32'd5;
        run_frame(2'b11, 1, 0, 0, 1'b0);

        // Wrap-around arithmetic.
        smp[0] = 32'd255; smp[1] = 32'd255;
        run_frame(2'b01, 2, 0, 0, 1'b0);
        smp[0] = 32'd256;
        run_frame(2'b01, 1, 0, 0, 1'b0);

        // Zero-length frame on channel 1.
        run_frame(2'b10, 0, 0, 0, 1'b0);

        // Stalls of 4 cycles between samples.
        smp[0] = 32'd1; smp[1] = 32'd1; smp[2] = 32'd1;
        run_frame(2'b01, 3, 4, 4, 1'b0);

        // Reset in the middle of a 4-sample frame.
        @(negedge clk);
        req  = 2'b01;
        len0 = LW'(4);
        saw_rv = 1'b0;
        for (int k = 0; k < 10 && grant == 2'b00; k++) @(negedge clk);
        check("abort_grant", 64'(grant), 64'd1);
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data  = 32'd7;
            @(negedge clk);
        end
        rst     = 1'b1;
        s_valid = 1'b0;
        req     = 2'b00;
        @(negedge clk);
        rst        = 1'b0;
        model_last = 1'b1;
        check("abort_grant0", 64'(grant), 64'd0);
        check("abort_busy0", 64'(busy), 64'd0);
        check("abort_s_ready0", 64'(s_ready), 64'd0);
        check("abort_result0", 64'(result), 64'd0);
        for (int k = 0; k < 8; k++) begin
            if (result_valid) saw_rv = 1'b1;
            @(negedge clk);
        end
        check("abort_no_rv", 64'(saw_rv), 64'd0);
        smp[0] = 32'd2;
        run_frame(2'b01, 1, 0, 0, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            int n;
            int gh;
            n  = $urandom_range(6, 0);
            gh = ($urandom_range(1, 0) == 0) ? 0 : 2;
            for (int i = 0; i < n; i++) smp[i] = $urandom;
            run_frame(2'($urandom_range(3, 1)), n, 0, gh, 1'($urandom_range(1, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
